// File: rtl/ci_initiator.sv
// Initiator for a multi-cycle custom-instruction responder: one request in, one start/done
// transaction out, result plus timeout status returned on a valid/ready response port.
module ci_initiator #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLD_START     = 0,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dataa,
  input  logic [DATA_W-1:0] req_datab,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_timeout,
  output logic [CNT_W-1:0]  resp_cycles,
  output logic              ci_clk_en,
  output logic              ci_reset,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result
);

  typedef enum logic [2:0] {RECOVER, IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dataa_q, dataa_d;
  logic [DATA_W-1:0]   datab_q, datab_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                tmo_q, tmo_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                rstp_q, rstp_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RECOVER;
      cnt_q    <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      result_q <= '0;
      tmo_q    <= 1'b0;
      cycles_q <= '0;
      rstp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
      cycles_q <= cycles_d;
      rstp_q   <= rstp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    cycles_d = cycles_q;
    rstp_d   = 1'b0;
    case (state_q)
      RECOVER: state_d = IDLE;
      IDLE: begin
        if (req_valid && enable) begin
          dataa_d = req_dataa;
          datab_d = req_datab;
          cnt_d   = CNT_ONE;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (enable) begin
          if (ci_done) begin
            result_d = ci_result;
            tmo_d    = 1'b0;
            cycles_d = cnt_q;
            state_d  = RESP;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (enable) begin
          if (ci_done) begin
            result_d = ci_result;
            tmo_d    = 1'b0;
            cycles_d = cnt_q;
            state_d  = RESP;
          end else if (cnt_q >= TMO) begin
            result_d = '0;
            tmo_d    = 1'b1;
            cycles_d = TMO;
            rstp_d   = 1'b1;
            state_d  = RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = RECOVER;
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_result  = result_q;
  assign resp_timeout = tmo_q;
  assign resp_cycles  = cycles_q;
  assign ci_clk_en    = enable;
  assign ci_reset     = (state_q == RECOVER) || rstp_q;
  assign ci_start     = (state_q == ISSUE) || ((state_q == WAIT) && (HOLD_START != 0));
  assign ci_dataa     = dataa_q;
  assign ci_datab     = datab_q;

endmodule

// File: tb/tb_ci_initiator.sv
// Bench for ci_initiator: two instances (pulsed and held start) driven against a GCD
// responder model with programmable latency; directed vector table plus reset sequences.
module tb_ci_initiator;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic resp_ready;

  logic          req_valid   [2];
  logic [DW-1:0] req_dataa   [2];
  logic [DW-1:0] req_datab   [2];
  logic          req_ready   [2];
  logic          resp_valid  [2];
  logic [DW-1:0] resp_result [2];
  logic          resp_timeout[2];
  logic [CW-1:0] resp_cycles [2];
  logic          ci_clk_en   [2];
  logic          ci_reset    [2];
  logic          ci_start    [2];
  logic [DW-1:0] ci_dataa    [2];
  logic [DW-1:0] ci_datab    [2];
  logic          ci_done     [2];
  logic [DW-1:0] ci_result   [2];

  // responder model state; lat: 0 never done, 1 combinational done, >1 done in that cycle of the op
  logic          busy[2];
  int            k   [2];
  logic [DW-1:0] mres[2];
  int            lat [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ci_initiator #(.DATA_W(DW), .TIMEOUT_CYCLES(16), .HOLD_START(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_dataa(req_dataa[0]), .req_datab(req_datab[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
    .resp_result(resp_result[0]), .resp_timeout(resp_timeout[0]), .resp_cycles(resp_cycles[0]),
    .ci_clk_en(ci_clk_en[0]), .ci_reset(ci_reset[0]), .ci_start(ci_start[0]),
    .ci_dataa(ci_dataa[0]), .ci_datab(ci_datab[0]),
    .ci_done(ci_done[0]), .ci_result(ci_result[0])
  );

  ci_initiator #(.DATA_W(DW), .TIMEOUT_CYCLES(16), .HOLD_START(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_dataa(req_dataa[1]), .req_datab(req_datab[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
    .resp_result(resp_result[1]), .resp_timeout(resp_timeout[1]), .resp_cycles(resp_cycles[1]),
    .ci_clk_en(ci_clk_en[1]), .ci_reset(ci_reset[1]), .ci_start(ci_start[1]),
    .ci_dataa(ci_dataa[1]), .ci_datab(ci_datab[1]),
    .ci_done(ci_done[1]), .ci_result(ci_result[1])
  );

  function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < 64 && y != 0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        busy[d] <= 1'b0;
        k[d]    <= 0;
        mres[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ci_reset[d]) busy[d] <= 1'b0;
        else if (ci_clk_en[d]) begin
          if (busy[d]) begin
            if (ci_done[d]) busy[d] <= 1'b0;
            else k[d] <= k[d] + 1;
          end else if (ci_start[d] && lat[d] != 1) begin
            busy[d] <= 1'b1;
            k[d]    <= 2;
            mres[d] <= gcd(ci_dataa[d], ci_datab[d]);
          end
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ci_done[d]   = (lat[d] == 1 && ci_start[d]) || (busy[d] && lat[d] > 1 && k[d] == lat[d]);
      ci_result[d] = (lat[d] == 1) ? gcd(ci_dataa[d], ci_datab[d]) : mres[d];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] er;
    int          ecyc;
    logic        etmo;
    int          estarts;
    int          hold;
    int          en_at;
  } vec_t;

  task automatic run_vec(input string p, input vec_t v);
    int n, starts, rstp, bad;
    lat[v.d]   = v.lat;
    resp_ready = (v.hold == 0);
    n = 0;
    while (!req_ready[v.d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({p, "_req_ready"}, req_ready[v.d], 1);
    req_valid[v.d] = 1'b1;
    req_dataa[v.d] = v.a;
    req_datab[v.d] = v.b;
    @(negedge clk);
    req_valid[v.d] = 1'b0;
    chk({p, "_start_n1"}, ci_start[v.d], 1);
    chk({p, "_dataa"}, ci_dataa[v.d], v.a);
    chk({p, "_datab"}, ci_datab[v.d], v.b);
    starts = 0; rstp = 0; bad = 0; n = 0;
    while (n < 100) begin
      if (n == v.en_at) enable = 1'b0;
      if (n == v.en_at + 3) enable = 1'b1;
      if (ci_start[v.d]) starts++;
      if (ci_reset[v.d]) rstp++;
      if (resp_valid[v.d]) break;
      if (req_ready[v.d]) bad++;
      @(negedge clk);
      n++;
    end
    enable = 1'b1;
    chk({p, "_resp_valid"}, resp_valid[v.d], 1);
    chk({p, "_result"}, resp_result[v.d], v.er);
    chk({p, "_timeout"}, resp_timeout[v.d], v.etmo);
    chk({p, "_cycles"}, resp_cycles[v.d], v.ecyc);
    chk({p, "_starts"}, starts, v.estarts);
    chk({p, "_ci_reset_pulses"}, rstp, v.etmo ? 1 : 0);
    chk({p, "_req_ready_busy"}, bad, 0);
    if (v.hold > 0) begin
      bad = 0;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        if (!resp_valid[v.d] || resp_result[v.d] !== v.er || req_ready[v.d]) bad++;
      end
      chk({p, "_hold_stable"}, bad, 0);
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({p, "_after_hs"}, {resp_valid[v.d], req_ready[v.d]}, 2'b01);
    chk({p, "_dataa_hold"}, ci_dataa[v.d], v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    vec_t fin;
    int   nv;
    //          d  a           b       lat er  cyc tmo starts hold en_at
    tbl[0]  = '{0, 32'd91,         32'd21,     5, 32'd7, 5,  1'b0, 1, 0, -1};
    tbl[1]  = '{0, 32'd2147483647, 32'd524287, 3, 32'd1, 3,  1'b0, 1, 0, -1};
    tbl[2]  = '{0, 32'd1,          32'd1,      2, 32'd1, 2,  1'b0, 1, 0, -1};
    tbl[3]  = '{0, 32'd1000000000, 32'd1,      4, 32'd1, 4,  1'b0, 1, 0, -1};
    tbl[4]  = '{0, 32'd2,          32'd1023,   3, 32'd1, 3,  1'b0, 1, 0, -1};
    tbl[5]  = '{0, 32'd91,         32'd21,     5, 32'd7, 5,  1'b0, 1, 8, -1};
    tbl[6]  = '{0, 32'd5,          32'd3,      0, 32'd0, 16, 1'b1, 1, 0, -1};
    tbl[7]  = '{0, 32'd91,         32'd21,     5, 32'd7, 5,  1'b0, 1, 0, -1};
    tbl[8]  = '{1, 32'd91,         32'd21,     1, 32'd7, 1,  1'b0, 1, 0, -1};
    tbl[9]  = '{1, 32'd91,         32'd21,     5, 32'd7, 5,  1'b0, 5, 0, -1};
    tbl[10] = '{1, 32'd2,          32'd1023,   5, 32'd1, 5,  1'b0, 8, 0, 2};

    rst = 1'b0; enable = 1'b1; resp_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_dataa[d] = '0; req_datab[d] = '0; lat[d] = 5;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_req_ready", d), req_ready[d], 0);
      chk($sformatf("rst%0d_resp_valid", d), resp_valid[d], 0);
      chk($sformatf("rst%0d_resp_result", d), resp_result[d], 0);
      chk($sformatf("rst%0d_resp_timeout", d), resp_timeout[d], 0);
      chk($sformatf("rst%0d_resp_cycles", d), resp_cycles[d], 0);
      chk($sformatf("rst%0d_ci_start", d), ci_start[d], 0);
      chk($sformatf("rst%0d_ci_dataa", d), ci_dataa[d], 0);
      chk($sformatf("rst%0d_ci_datab", d), ci_datab[d], 0);
      chk($sformatf("rst%0d_ci_reset", d), ci_reset[d], 1);
      chk($sformatf("rst%0d_ci_clk_en", d), ci_clk_en[d], 1);
    end
    rst = 1'b1;
    #1;
    chk("recover_ci_reset", ci_reset[0], 1);
    chk("recover_req_ready", req_ready[0], 0);
    @(negedge clk);
    chk("idle_ci_reset", ci_reset[0], 0);
    chk("idle_req_ready", req_ready[0], 1);

    nv = 11;
    for (int i = 0; i < nv; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // abort an outstanding transaction with reset while waiting for done
    lat[0] = 0;
    resp_ready = 1'b1;
    req_valid[0] = 1'b1; req_dataa[0] = 32'd91; req_datab[0] = 32'd21;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_resp_valid", resp_valid[0], 0);
    chk("abort_ci_start", ci_start[0], 0);
    chk("abort_ci_reset", ci_reset[0], 1);
    chk("abort_req_ready", req_ready[0], 0);
    chk("abort_ci_dataa", ci_dataa[0], 0);
    rst = 1'b1;
    #1;
    chk("abort_recover_ci_reset", ci_reset[0], 1);
    @(negedge clk);
    chk("abort_idle_ci_reset", ci_reset[0], 0);
    chk("abort_idle_req_ready", req_ready[0], 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (resp_valid[0]) seen++;
        @(negedge clk);
      end
      chk("abort_no_response", seen, 0);
    end
    fin = '{0, 32'd91, 32'd21, 5, 32'd7, 5, 1'b0, 1, 0, -1};
    run_vec("post_abort", fin);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
